// File: rtl/heartbeat_gen_if.sv
// Bus between the heartbeat source and its driver.
// Carries task check-ins and controls inward, and heartbeat and miss status outward.
interface heartbeat_gen_if #(
    parameter int unsigned NUM_TASKS  = 4,
    parameter int unsigned MISS_LIMIT = 3
);
    localparam int unsigned MC_W = $clog2(MISS_LIMIT + 1);

    logic                 enable;
    logic [NUM_TASKS-1:0] task_mask;
    logic [NUM_TASKS-1:0] checkin;
    logic                 fault_clear;
    logic                 heartbeat;
    logic                 fault;
    logic [NUM_TASKS-1:0] missed_mask;
    logic [MC_W-1:0]      miss_count;

    modport master (
        output enable, task_mask, checkin, fault_clear,
        input  heartbeat, fault, missed_mask, miss_count
    );

    modport slave (
        input  enable, task_mask, checkin, fault_clear,
        output heartbeat, fault, missed_mask, miss_count
    );
endinterface

// File: rtl/heartbeat_gen.sv
// Watchdog heartbeat source: emits one pulse per window in which every required
// task checked in, and latches a sticky fault after MISS_LIMIT bad windows in a row.
module heartbeat_gen #(
    parameter int unsigned NUM_TASKS     = 4,
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned WINDOW_CYCLES = 5000000,
    parameter int unsigned MISS_LIMIT    = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    heartbeat_gen_if.slave  bus
);
    localparam int unsigned MC_W = $clog2(MISS_LIMIT + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] EMIT    = 2'd2;
    localparam logic [1:0] FAULT   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [MC_W-1:0]  MISS_MAX  = MC_W'(MISS_LIMIT);

    logic [1:0]           state,       state_nxt;
    logic [CNT_W-1:0]     cnt,         cnt_nxt;
    logic [NUM_TASKS-1:0] seen,        seen_nxt;
    logic [NUM_TASKS-1:0] req,         req_nxt;
    logic [NUM_TASKS-1:0] missed,      missed_nxt;
    logic [MC_W-1:0]      miss_cnt,    miss_cnt_nxt;
    logic                 heartbeat_r, fault_r;

    logic [NUM_TASKS-1:0] seen_now;
    logic                 win_end;
    logic                 pass;
    logic [MC_W-1:0]      miss_inc;

    // State and status registers; heartbeat/fault are decoded from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            seen        <= '0;
            req         <= '0;
            missed      <= '0;
            miss_cnt    <= '0;
            heartbeat_r <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            seen        <= seen_nxt;
            req         <= req_nxt;
            missed      <= missed_nxt;
            miss_cnt    <= miss_cnt_nxt;
            heartbeat_r <= (state_nxt == EMIT);
            fault_r     <= (state_nxt == FAULT);
        end
    end

    // Next-state and window evaluation
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        seen_nxt     = seen;
        req_nxt      = req;
        missed_nxt   = missed;
        miss_cnt_nxt = miss_cnt;

        seen_now = seen | bus.checkin;
        win_end  = (cnt == CNT_LAST);
        pass     = ((seen_now & req) == req);
        miss_inc = (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + MC_W'(1);

        case (state)
            IDLE: begin
                if (bus.enable) begin
                    state_nxt = COLLECT;
                    cnt_nxt   = '0;
                    seen_nxt  = '0;
                    req_nxt   = bus.task_mask;
                end
            end
            COLLECT: begin
                if (!bus.enable) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    seen_nxt  = '0;
                end else if (win_end) begin
                    cnt_nxt  = '0;
                    seen_nxt = '0;
                    req_nxt  = bus.task_mask;
                    if (pass) begin
                        state_nxt    = EMIT;
                        miss_cnt_nxt = '0;
                    end else begin
                        missed_nxt   = req & ~seen_now;
                        miss_cnt_nxt = miss_inc;
                        if (miss_inc == MISS_MAX) begin
                            state_nxt = FAULT;
                        end
                    end
                end else begin
                    cnt_nxt  = cnt + CNT_W'(1);
                    seen_nxt = seen_now;
                end
            end
            EMIT: begin
                // EMIT is outside any window but its check-ins carry into the next one
                if (!bus.enable) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    seen_nxt  = '0;
                end else begin
                    state_nxt = COLLECT;
                    seen_nxt  = seen_now;
                end
            end
            FAULT: begin
                cnt_nxt  = '0;
                seen_nxt = '0;
                if (bus.fault_clear) begin
                    state_nxt    = IDLE;
                    miss_cnt_nxt = '0;
                    missed_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                seen_nxt  = '0;
            end
        endcase
    end

    assign bus.heartbeat   = heartbeat_r;
    assign bus.fault       = fault_r;
    assign bus.missed_mask = missed;
    assign bus.miss_count  = miss_cnt;
endmodule

// File: tb/tb_heartbeat_gen.sv
// Directed bench for heartbeat_gen: window-level vector table plus hand-written
// sequences for reset, fault recovery and enable drop mid-window.
module tb_heartbeat_gen;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    heartbeat_gen_if #(.NUM_TASKS(4), .MISS_LIMIT(3)) bus ();

    heartbeat_gen #(
        .NUM_TASKS(4),
        .CNT_W(24),
        .WINDOW_CYCLES(8),
        .MISS_LIMIT(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    typedef struct {
        logic [3:0] mask;
        logic [3:0] ci0;
        logic [3:0] ci7;
        logic [3:0] ci_emit;
        logic       fc0;
        logic       ehb;
        logic       efault;
        logic [3:0] emiss;
        logic [1:0] emc;
    } win_vec_t;

    localparam int NV = 12;
    win_vec_t vec [NV];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // One clock with the given check-ins; outputs are valid on return
    task automatic step(input logic [3:0] ci);
        bus.checkin = ci;
        @(posedge clk);
        #1;
        bus.checkin     = 4'h0;
        bus.fault_clear = 1'b0;
    endtask

    function automatic logic [31:0] outs();
        return {23'd0, bus.heartbeat, bus.fault, bus.missed_mask, bus.miss_count};
    endfunction

    function automatic logic [31:0] pack(input logic hb, input logic f, input logic [3:0] m,
                                         input logic [1:0] mc);
        return {23'd0, hb, f, m, mc};
    endfunction

    // One 8-cycle window starting at counter 0, plus the EMIT cycle on a pass
    task automatic run_win(input string nm, input win_vec_t v, input logic [1:0] prev_mc);
        bus.task_mask = v.mask;
        for (int c = 0; c < 8; c++) begin
            bus.fault_clear = (c == 0) ? v.fc0 : 1'b0;
            step((c == 0) ? v.ci0 : (c == 7) ? v.ci7 : 4'h0);
            if (c < 7) check({nm, "_mid"}, {30'd0, bus.heartbeat, bus.fault},
                             32'd0);
            if (c < 7) check({nm, "_mid_mc"}, 32'(bus.miss_count), 32'(prev_mc));
        end
        check({nm, "_end"}, outs(), pack(v.ehb, v.efault, v.emiss, v.emc));
        if (v.ehb) begin
            step(v.ci_emit);
            check({nm, "_post_emit"}, 32'(bus.heartbeat), 32'd0);
        end
    endtask

    initial begin
        logic [1:0] prev_mc;
        win_vec_t   w;

        //             mask  ci0   ci7   emit  fc    hb    flt   miss  mc
        vec[0]  = '{4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0};
        vec[1]  = '{4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0};
        vec[2]  = '{4'hF, 4'hB, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h4, 2'd1};
        vec[3]  = '{4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h4, 2'd0};
        vec[4]  = '{4'hF, 4'h7, 4'h8, 4'h8, 1'b0, 1'b1, 1'b0, 4'h4, 2'd0};
        vec[5]  = '{4'hF, 4'h7, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h4, 2'd0};
        vec[6]  = '{4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h4, 2'd0};
        vec[7]  = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h4, 2'd0};
        vec[8]  = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h4, 2'd0};
        vec[9]  = '{4'hF, 4'hE, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h1, 2'd1};
        vec[10] = '{4'hF, 4'hE, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h1, 2'd2};
        vec[11] = '{4'hF, 4'hE, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 2'd3};

        bus.enable      = 1'b0;
        bus.task_mask   = 4'hF;
        bus.checkin     = 4'h0;
        bus.fault_clear = 1'b0;
        reset_n         = 1'b0;
        #12;
        check("reset_state", outs(), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle with enable low
        for (int i = 0; i < 20; i++) begin
            step(4'h0);
            check("idle", outs(), 32'd0);
        end

        // Enter COLLECT, then the window table
        bus.enable = 1'b1;
        step(4'h0);
        check("enter_collect", outs(), 32'd0);
        prev_mc = 2'd0;
        for (int i = 0; i < NV; i++) begin
            run_win($sformatf("win%0d", i), vec[i], prev_mc);
            prev_mc = vec[i].emc;
        end

        // FAULT holds regardless of check-ins and enable
        for (int i = 0; i < 12; i++) begin
            bus.enable = (i >= 4 && i < 8) ? 1'b0 : 1'b1;
            step(4'hF);
            check("fault_hold", outs(), pack(1'b0, 1'b1, 4'h1, 2'd3));
        end
        bus.fault_clear = 1'b1;
        step(4'h0);
        check("fault_clear", outs(), 32'd0);
        step(4'h0);
        check("clear_to_collect", outs(), 32'd0);
        w = '{4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0};
        run_win("after_clear", w, 2'd0);

        // Async reset at counter 5 after a miss
        w = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'hF, 2'd1};
        run_win("pre_reset_miss", w, 2'd0);
        step(4'hF);
        for (int i = 0; i < 4; i++) step(4'h0);
        reset_n = 1'b0;
        #1;
        check("reset_midwin", outs(), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(4'h0);
        check("reset_to_collect", outs(), 32'd0);
        w = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'hF, 2'd1};
        run_win("post_reset_win", w, 2'd0);

        // enable drop at counter 5 holds miss status, clears window
        step(4'hF);
        for (int i = 0; i < 4; i++) step(4'h0);
        bus.enable = 1'b0;
        step(4'h0);
        check("disable_midwin", outs(), pack(1'b0, 1'b0, 4'hF, 2'd1));
        for (int i = 0; i < 3; i++) begin
            step(4'h0);
            check("disabled_idle", outs(), pack(1'b0, 1'b0, 4'hF, 2'd1));
        end
        bus.enable = 1'b1;
        step(4'h0);
        w = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'hF, 2'd2};
        run_win("post_disable_win", w, 2'd1);
        w = '{4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'hF, 2'd0};
        run_win("recover_win", w, 2'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
